// File: rtl/dice_led_scanner.sv
// Time-multiplexed pip driver for N_DICE dice on a shared 9-LED bus.
// Values are taken through valid/ready and only become visible at a frame boundary.
module dice_led_scanner #(
  parameter int unsigned N_DICE   = 2,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*N_DICE-1:0]   in_values,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  lamp_test,
  output logic [8:0]            led,
  output logic [N_DICE-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (N_DICE > 1) ? $clog2(N_DICE) : 1;

  logic                  run_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [3*N_DICE-1:0]   active_q, active_d;
  logic [3*N_DICE-1:0]   shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [8:0]            led_q, led_d;
  logic [N_DICE-1:0]     dig_sel_q, dig_sel_d;
  logic                  frame_done_q, frame_done_d;
  logic                  in_ready_q, in_ready_d;

  logic       slot_wrap, frame_wrap, accept, pwm_en;
  logic [2:0] cur_val;

  function automatic logic [8:0] pip(input logic [2:0] v);
    logic [8:0] p;
    unique case (v)
      3'd0: p = 9'b000_000_000;
      3'd1: p = 9'b000_010_000;
      3'd2: p = 9'b100_000_001;
      3'd3: p = 9'b100_010_001;
      3'd4: p = 9'b101_000_101;
      3'd5: p = 9'b101_010_101;
      3'd6: p = 9'b101_101_101;
      3'd7: p = 9'b111_101_111;
      default: p = 9'b000_000_000;
    endcase
    return p;
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pwm_d        = pwm_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    cur_val      = 3'd0;
    dig_sel_d    = '0;
    led_d        = '0;

    slot_wrap  = run_q && (cnt_q == CntW'(SCAN_DIV - 1));
    frame_wrap = slot_wrap && (idx_q == IdxW'(N_DICE - 1));
    accept     = in_valid && in_ready_q;

    // The first edge out of reset only starts slot 0; counting begins after it.
    if (run_q) begin
      cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
      pwm_d = pwm_q + 1'b1;
      if (slot_wrap) begin
        idx_d = frame_wrap ? '0 : idx_q + 1'b1;
      end
    end

    // The frame-start edge is the only place the displayed set may change.
    if (frame_wrap) begin
      if (accept) begin
        active_d = in_values;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = in_values;
      pending_d = 1'b1;
    end

    in_ready_d   = !pending_d;
    frame_done_d = frame_wrap;

    for (int unsigned i = 0; i < N_DICE; i++) begin
      dig_sel_d[i] = (idx_d == IdxW'(i));
      if (idx_d == IdxW'(i)) begin
        cur_val = active_d[3*i +: 3];
      end
    end

    pwm_en = (&brightness) || (pwm_d < brightness);
    if (cnt_d != '0) begin
      if (lamp_test) begin
        led_d = 9'h1FF;
      end else if (pwm_en) begin
        led_d = pip(cur_val);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      led_q        <= '0;
      dig_sel_q    <= '0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      led_q        <= led_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign led        = led_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;
  assign in_ready   = in_ready_q;

endmodule

// File: tb/tb_dice_led_scanner.sv
// Bench for dice_led_scanner: a 2-die and a 1-die instance checked every cycle against a
// time-based model, plus directed sequences for handshake, PWM, lamp test and reset.
module tb_dice_led_scanner;

  localparam int Div = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid_a = 1'b0;
  logic       in_valid_b = 1'b0;
  logic [5:0] in_values_a = '0;
  logic [2:0] in_values_b = '0;
  logic [3:0] brightness = 4'hF;
  logic       lamp_test = 1'b0;
  logic       in_ready_a, in_ready_b, frame_done_a, frame_done_b;
  logic [8:0] led_a, led_b;
  logic [1:0] dig_sel_a;
  logic [0:0] dig_sel_b;

  dice_led_scanner #(.N_DICE(2), .SCAN_DIV(Div), .PWM_BITS(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_values  (in_values_a),
    .brightness (brightness),
    .lamp_test  (lamp_test),
    .led        (led_a),
    .dig_sel    (dig_sel_a),
    .frame_done (frame_done_a)
  );

  dice_led_scanner #(.N_DICE(1), .SCAN_DIV(Div), .PWM_BITS(4)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_values  (in_values_b),
    .brightness (brightness),
    .lamp_test  (lamp_test),
    .led        (led_b),
    .dig_sel    (dig_sel_b),
    .frame_done (frame_done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] value;
    logic [8:0] pattern;
  } vec_t;
  vec_t tv[8];

  logic [8:0] exp1[8];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: everything follows from t = cycles since the start edge.
  bit         m_started[2];
  int         m_t[2];
  logic [5:0] m_act[2];
  logic [5:0] m_shd[2];
  bit         m_pend[2];
  bit         m_rdy[2];
  bit         m_fd[2];
  logic [8:0] m_led[2];
  logic [1:0] m_sel[2];
  int         nd[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int d, input logic iv, input logic [5:0] vals);
    bit         acc, fs;
    int         idx, p;
    logic [2:0] v;
    if (!rst_n) begin
      m_started[d] = 0; m_t[d] = 0; m_act[d] = '0; m_shd[d] = '0; m_pend[d] = 0;
      m_rdy[d] = 0; m_fd[d] = 0; m_led[d] = '0; m_sel[d] = '0;
      return;
    end
    acc = iv && m_rdy[d];
    if (!m_started[d]) begin
      m_started[d] = 1;
      m_t[d] = 0;
      fs = 0;
    end else begin
      m_t[d]++;
      fs = (m_t[d] % (Div * nd[d])) == 0;
    end
    if (fs) begin
      if (acc) m_act[d] = vals;
      else if (m_pend[d]) m_act[d] = m_shd[d];
      m_pend[d] = 0;
    end else if (acc) begin
      m_shd[d] = vals;
      m_pend[d] = 1;
    end
    m_rdy[d] = !m_pend[d];
    m_fd[d]  = fs;
    idx      = (m_t[d] / Div) % nd[d];
    m_sel[d] = 2'(1 << idx);
    p        = m_t[d] % 16;
    v        = 3'(m_act[d] >> (3 * idx));
    if (m_t[d] % Div == 0) m_led[d] = '0;
    else if (lamp_test) m_led[d] = 9'h1FF;
    else if (brightness == 4'hF || p < int'(brightness)) m_led[d] = tv[v].pattern;
    else m_led[d] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, in_valid_a, in_values_a);
    model_edge(1, in_valid_b, {3'b000, in_values_b});
    #1;
    check("led_a",        32'(led_a),        32'(m_led[0]));
    check("dig_sel_a",    32'(dig_sel_a),    32'(m_sel[0]));
    check("in_ready_a",   32'(in_ready_a),   32'(m_rdy[0]));
    check("frame_done_a", 32'(frame_done_a), 32'(m_fd[0]));
    check("led_b",        32'(led_b),        32'(m_led[1]));
    check("dig_sel_b",    32'(dig_sel_b),    32'(m_sel[1]));
    check("in_ready_b",   32'(in_ready_b),   32'(m_rdy[1]));
    check("frame_done_b", 32'(frame_done_b), 32'(m_fd[1]));
  endtask

  task automatic wait_fd(input int d, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = (d == 0) ? frame_done_a : frame_done_b;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int low, gap, nz, n1ff, nother, n101, n1ef;

    tv[0] = '{3'd0, 9'h000}; tv[1] = '{3'd1, 9'h010};
    tv[2] = '{3'd2, 9'h101}; tv[3] = '{3'd3, 9'h111};
    tv[4] = '{3'd4, 9'h145}; tv[5] = '{3'd5, 9'h155};
    tv[6] = '{3'd6, 9'h16D}; tv[7] = '{3'd7, 9'h1EF};
    exp1 = '{9'h000, 9'h010, 9'h010, 9'h010, 9'h000, 9'h16D, 9'h16D, 9'h16D};
    nd[0] = 2;
    nd[1] = 1;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    check("rst_led",   32'(led_a),        32'd0);
    check("rst_sel",   32'(dig_sel_a),    32'd0);
    check("rst_ready", 32'(in_ready_a),   32'd0);
    check("rst_fd",    32'(frame_done_a), 32'd0);
    rst_n = 1'b1;
    step();
    check("start_ready", 32'(in_ready_a), 32'd1);
    check("start_sel",   32'(dig_sel_a),  32'd1);

    // Load die0=1, die1=6; visible from the next frame
    in_values_a = {3'd6, 3'd1};
    in_valid_a  = 1'b1;
    step();
    in_valid_a = 1'b0;
    wait_fd(0, "t1_frame");
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      check("t1_led_seq", 32'(led_a), 32'(exp1[k]));
    end

    // Mid-frame load; a second set is held off until the frame boundary
    step();
    step();
    in_values_a = {3'd3, 3'd2};
    in_valid_a  = 1'b1;
    step();
    in_values_a = {3'd5, 3'd4};
    low = 0;
    while (!in_ready_a && low < 20) begin
      step();
      low++;
    end
    check("t2_ready_at_frame", 32'(frame_done_a), 32'd1);
    check("t2_hold_len", 32'(low <= 8), 32'd1);
    step();
    in_valid_a = 1'b0;
    wait_fd(0, "t2_frame");
    gap = 0;
    do begin
      step();
      gap++;
    end while (!frame_done_a && gap < 20);
    check("t2_frame_period", 32'(gap), 32'd8);

    // PWM duty
    brightness = 4'd0;
    nz = 0;
    repeat (32) begin
      step();
      if (led_a != 0) nz++;
    end
    check("t3_bright0", 32'(nz), 32'd0);
    brightness = 4'd4;
    nz = 0;
    repeat (32) begin
      step();
      if (led_a != 0) nz++;
    end
    check("t3_bright4", 32'(nz), 32'd6);

    // Lamp test overrides zero values and zero brightness
    brightness  = 4'd0;
    in_values_a = '0;
    in_valid_a  = 1'b1;
    step();
    in_valid_a = 1'b0;
    wait_fd(0, "t4_frame");
    lamp_test = 1'b1;
    n1ff = 0;
    nother = 0;
    repeat (16) begin
      step();
      if (led_a == 9'h1FF) n1ff++;
      else if (led_a != 0) nother++;
    end
    check("t4_lamp_on", 32'(n1ff), 32'd12);
    check("t4_lamp_other", 32'(nother), 32'd0);
    lamp_test = 1'b0;

    // Reset with pending data discards it
    brightness  = 4'hF;
    in_values_a = {3'd2, 3'd2};
    in_valid_a  = 1'b1;
    step();
    in_valid_a = 1'b0;
    step();
    check("t5_pending", 32'(in_ready_a), 32'd0);
    rst_n = 1'b0;
    step();
    check("t5_rst_led",   32'(led_a),        32'd0);
    check("t5_rst_sel",   32'(dig_sel_a),    32'd0);
    check("t5_rst_fd",    32'(frame_done_a), 32'd0);
    check("t5_rst_ready", 32'(in_ready_a),   32'd0);
    rst_n = 1'b1;
    step();
    in_values_a = {3'd7, 3'd7};
    in_valid_a  = 1'b1;
    step();
    in_valid_a = 1'b0;
    n101 = 0;
    n1ef = 0;
    repeat (24) begin
      step();
      if (led_a == 9'h101) n101++;
      if (led_a == 9'h1EF) n1ef++;
    end
    check("t5_old_shadow", 32'(n101), 32'd0);
    check("t5_seven", 32'(n1ef > 0), 32'd1);

    // Single-die value sweep
    for (int i = 0; i < 8; i++) begin
      in_values_b = tv[i].value;
      in_valid_b  = 1'b1;
      step();
      in_valid_b = 1'b0;
      wait_fd(1, "t6_frame");
      step();
      check("t6_led_map", 32'(led_b), 32'(tv[i].pattern));
      step();
      step();
      step();
      check("t6_period", 32'(frame_done_b), 32'd1);
    end

    // Random traffic with occasional resets
    repeat (400) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      in_valid_a  = 1'($urandom);
      in_valid_b  = 1'($urandom);
      in_values_a = 6'($urandom);
      in_values_b = 3'($urandom);
      brightness  = 4'($urandom);
      lamp_test   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
